// File: rtl/mesi_snoop_if.sv
// mesi_snoop_if: bundles the snoop agent's bus-facing signals.
//   cbus_* : command/address from the ISC and the one-cycle completion pulse back
//   wb_*   : write-back request/address to memory and its accept strobe
//   cpu_wr_*: local CPU store-hit notification and its same-cycle accept
// Modports:
//   master - the environment side (ISC, memory, local CPU)
//   slave  - the snoop agent
interface mesi_snoop_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [2:0]            cbus_cmd_i;
  logic [ADDR_WIDTH-1:0] cbus_addr_i;
  logic                  cbus_ack_o;
  logic                  wb_req_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic                  wb_ack_i;
  logic                  cpu_wr_vld_i;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr_i;
  logic                  cpu_wr_rdy_o;

  modport master (
    output cbus_cmd_i, cbus_addr_i, wb_ack_i, cpu_wr_vld_i, cpu_wr_addr_i,
    input  cbus_ack_o, wb_req_o, wb_addr_o, cpu_wr_rdy_o
  );

  modport slave (
    input  cbus_cmd_i, cbus_addr_i, wb_ack_i, cpu_wr_vld_i, cpu_wr_addr_i,
    output cbus_ack_o, wb_req_o, wb_addr_o, cpu_wr_rdy_o
  );
endinterface

// File: rtl/mesi_snoop_agent.sv
// mesi_snoop_agent: per-CPU coherence snoop agent sitting behind the ISC.
// Holds a direct-mapped MESI tag/state table, services ISC commands
// (snoops and line installs), writes back dirty lines to memory and returns
// a one-cycle ack. Local CPU store hits on E lines upgrade silently to M.
// Ports:
//   clk             clock
//   rst             asynchronous reset, active-low
//   bus (slave)     cbus cmd/addr/ack, write-back req/addr/ack, cpu store vld/addr/rdy
// Optional build macro MESI_SNOOP_STATS_EN adds:
//   snoop_hit_cnt_o saturating count of WR/RD snoop hits
//   wb_cnt_o        saturating count of accepted write-backs
module mesi_snoop_agent #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic clk,
  input  logic rst,
  mesi_snoop_if.slave bus
`ifdef MESI_SNOOP_STATS_EN
  ,
  output logic [15:0] snoop_hit_cnt_o,
  output logic [15:0] wb_cnt_o
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, ACK, DRAIN} fsm_e;

  fsm_e                  fsm_q;
  logic [2:0]            cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ack_q;
  logic                  wb_req_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;

  mesi_e                 line_state_q [LINES];
  logic [TAG_W-1:0]      line_tag_q   [LINES];

  // Lookup of the registered command's line.
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  mesi_e                 cur_st;
  logic [TAG_W-1:0]      cur_tag;
  logic                  hit;

  assign idx     = addr_q[IDX_W-1:0];
  assign tag     = addr_q[ADDR_WIDTH-1:IDX_W];
  assign cur_st  = line_state_q[idx];
  assign cur_tag = line_tag_q[idx];
  assign hit     = (cur_st != ST_I) && (cur_tag == tag);

  // Decision for the current command; consumed in LOOKUP (write-back) and
  // ACK (table update). The entry cannot change in between because local
  // stores are only taken in IDLE.
  logic                  need_wb;
  logic [ADDR_WIDTH-1:0] wb_line;
  logic                  upd_en;
  mesi_e                 upd_st;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    need_wb = 1'b0;
    wb_line = addr_q;
    upd_en  = 1'b0;
    upd_st  = cur_st;
    case (cmd_q)
      CMD_WR_SNOOP: if (hit) begin
        upd_en  = 1'b1;
        upd_st  = ST_I;
        need_wb = (cur_st == ST_M);
      end
      CMD_RD_SNOOP: if (hit && (cur_st == ST_M || cur_st == ST_E)) begin
        upd_en  = 1'b1;
        upd_st  = ST_S;
        need_wb = (cur_st == ST_M);
      end
      CMD_EN_WR, CMD_EN_RD: begin
        upd_en = 1'b1;
        upd_st = (cmd_q == CMD_EN_WR) ? ST_M : ST_E;
        // A dirty line of another tag is being evicted: flush it first.
        if (cur_st == ST_M && cur_tag != tag) begin
          need_wb = 1'b1;
          wb_line = {cur_tag, idx};
        end
      end
      default: ;
    endcase
  end

  // Local store path: accepted only when idle with no pending ISC command,
  // so a simultaneous snoop always wins.
  logic [IDX_W-1:0] st_idx;
  logic             store_acc;
  logic             store_hit_e;

  assign st_idx      = bus.cpu_wr_addr_i[IDX_W-1:0];
  assign store_acc   = rst && (fsm_q == IDLE) && (bus.cbus_cmd_i == CMD_NOP) && bus.cpu_wr_vld_i;
  assign store_hit_e = (line_state_q[st_idx] == ST_E) &&
                       (line_tag_q[st_idx] == bus.cpu_wr_addr_i[ADDR_WIDTH-1:IDX_W]);

  assign bus.cpu_wr_rdy_o = store_acc;
  assign bus.cbus_ack_o   = ack_q;
  assign bus.wb_req_o     = wb_req_q;
  assign bus.wb_addr_o    = wb_addr_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= IDLE;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      ack_q     <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_addr_q <= '0;
      // NOTE: only the state bits are reset (every line invalid); the tags
      // are don't-care while invalid and live in a reset-free block below.
      for (int i = 0; i < LINES; i++) line_state_q[i] <= ST_I;
    end else begin
      ack_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (bus.cbus_cmd_i != CMD_NOP) begin
            cmd_q  <= bus.cbus_cmd_i;
            addr_q <= bus.cbus_addr_i;
            fsm_q  <= LOOKUP;
          end else if (store_acc && store_hit_e) begin
            line_state_q[st_idx] <= ST_M;
          end
        end
        LOOKUP: begin
          if (need_wb) begin
            wb_req_q  <= 1'b1;
            wb_addr_q <= wb_line;
            fsm_q     <= WB;
          end else begin
            ack_q <= 1'b1;
            fsm_q <= ACK;
          end
        end
        WB: begin
          if (bus.wb_ack_i) begin
            wb_req_q <= 1'b0;
            ack_q    <= 1'b1;
            fsm_q    <= ACK;
          end
        end
        ACK: begin
          if (upd_en) line_state_q[idx] <= upd_st;
          fsm_q <= DRAIN;
        end
        DRAIN: begin
          // The ISC holds its command until it sees the ack; wait it out so
          // one command yields exactly one ack.
          if (bus.cbus_cmd_i == CMD_NOP) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fsm_q == ACK && upd_en) line_tag_q[idx] <= tag;
  end

`ifdef MESI_SNOOP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snoop_hit_cnt_o <= '0;
      wb_cnt_o        <= '0;
    end else begin
      if (fsm_q == ACK && hit && (cmd_q == CMD_WR_SNOOP || cmd_q == CMD_RD_SNOOP) &&
          snoop_hit_cnt_o != 16'hFFFF)
        snoop_hit_cnt_o <= snoop_hit_cnt_o + 16'd1;
      if (fsm_q == WB && bus.wb_ack_i && wb_cnt_o != 16'hFFFF)
        wb_cnt_o <= wb_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mesi_snoop_agent.sv
// tb_mesi_snoop_agent: self-checking bench for mesi_snoop_agent.
// Keeps a line-address/state model of the table derived from the MESI
// command rules and compares handshake timing, write-back addresses and
// table contents after directed scenarios and a randomized command mix.
module tb_mesi_snoop_agent;
  localparam int AW    = 32;
  localparam int LINES = 16;
  localparam int IW    = $clog2(LINES);

  localparam int NOP = 0, WRS = 1, RDS = 2, ENW = 3, ENR = 4;
  localparam int I = 0, S = 1, E = 2, M = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesi_snoop_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef MESI_SNOOP_STATS_EN
  logic [15:0] snoop_hit_cnt;
  logic [15:0] wb_cnt;
`endif

  mesi_snoop_agent #(.ADDR_WIDTH(AW), .LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MESI_SNOOP_STATS_EN
    ,
    .snoop_hit_cnt_o (snoop_hit_cnt),
    .wb_cnt_o        (wb_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: per index, the full line address held and its MESI state.
  int            m_st   [LINES];
  logic [AW-1:0] m_line [LINES];
  int            m_hits;
  int            m_wbs;

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_st[i]   = I;
      m_line[i] = '0;
    end
    m_hits = 0;
    m_wbs  = 0;
  endfunction

  // Expected outcome of one ISC command from the MESI rules.
  task automatic predict(input int cmd, input logic [AW-1:0] a, output bit wb,
                         output logic [AW-1:0] wa, output int nst, output bit shit);
    int ix;
    bit present;
    ix      = int'(a[IW-1:0]);
    present = (m_st[ix] != I) && (m_line[ix] == a);
    wb   = 1'b0;
    wa   = a;
    nst  = m_st[ix];
    shit = 1'b0;
    case (cmd)
      WRS: if (present) begin shit = 1'b1; wb = (m_st[ix] == M); nst = I; end
      RDS: if (present) begin shit = 1'b1; wb = (m_st[ix] == M); nst = S; end
      ENW, ENR: begin
        nst = (cmd == ENW) ? M : E;
        if (m_st[ix] == M && m_line[ix] != a) begin wb = 1'b1; wa = m_line[ix]; end
      end
      default: ;
    endcase
  endtask

  // Drive one ISC command through to IDLE, checking timing on the way.
  task automatic run_cmd(input string label, input int cmd, input logic [AW-1:0] a,
                         input int wb_dly, input int hold);
    bit wb, shit;
    logic [AW-1:0] wa;
    int nst, ix;
    predict(cmd, a, wb, wa, nst, shit);
    ix = int'(a[IW-1:0]);
    bus.cbus_cmd_i  = 3'(cmd);
    bus.cbus_addr_i = a;
    #1;
    tests++;
    if (bus.cpu_wr_rdy_o !== 1'b0) begin
      fails++; $display("FAIL %s rdy_with_cmd: got %b need 0", label, bus.cpu_wr_rdy_o);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.cbus_ack_o !== 1'b0 || bus.wb_req_o !== 1'b0) begin
      fails++; $display("FAIL %s lookup: ack=%b wb_req=%b need 0/0", label, bus.cbus_ack_o, bus.wb_req_o);
    end
    @(posedge clk); #1;
    if (wb) begin
      tests++;
      if (bus.wb_req_o !== 1'b1 || bus.wb_addr_o !== wa || bus.cbus_ack_o !== 1'b0) begin
        fails++; $display("FAIL %s wb_start: req=%b addr=%h ack=%b need 1/%h/0",
                          label, bus.wb_req_o, bus.wb_addr_o, bus.cbus_ack_o, wa);
      end
      repeat (wb_dly) begin
        @(posedge clk); #1;
        tests++;
        if (bus.wb_req_o !== 1'b1 || bus.wb_addr_o !== wa || bus.cbus_ack_o !== 1'b0) begin
          fails++; $display("FAIL %s wb_hold: req=%b addr=%h ack=%b need 1/%h/0",
                            label, bus.wb_req_o, bus.wb_addr_o, bus.cbus_ack_o, wa);
        end
      end
      bus.wb_ack_i = 1'b1;
      @(posedge clk); #1;
      bus.wb_ack_i = 1'b0;
      m_wbs++;
      tests++;
      if (bus.wb_req_o !== 1'b0) begin
        fails++; $display("FAIL %s wb_drop: req=%b need 0", label, bus.wb_req_o);
      end
    end
    tests++;
    if (bus.cbus_ack_o !== 1'b1) begin
      fails++; $display("FAIL %s ack: got %b need 1", label, bus.cbus_ack_o);
    end
    repeat (hold + 1) begin
      @(posedge clk); #1;
      tests++;
      if (bus.cbus_ack_o !== 1'b0) begin
        fails++; $display("FAIL %s ack_single: got %b need 0", label, bus.cbus_ack_o);
      end
    end
    bus.cbus_cmd_i = 3'(NOP);
    @(posedge clk); #1;
    m_st[ix] = nst;
    if (cmd == ENW || cmd == ENR) m_line[ix] = a;
    if (shit) m_hits++;
    tests++;
    if (dut.line_state_q[ix] !== 2'(nst)) begin
      fails++; $display("FAIL %s entry_state[%0d]: got %0d need %0d", label, ix, dut.line_state_q[ix], nst);
    end
    if (nst != I) begin
      tests++;
      if (dut.line_tag_q[ix] !== m_line[ix][AW-1:IW]) begin
        fails++; $display("FAIL %s entry_tag[%0d]: got %h need %h", label, ix, dut.line_tag_q[ix], m_line[ix][AW-1:IW]);
      end
    end
  endtask

  // Local store while idle with no command: must be accepted.
  task automatic cpu_store(input string label, input logic [AW-1:0] a);
    int ix;
    ix = int'(a[IW-1:0]);
    bus.cpu_wr_vld_i  = 1'b1;
    bus.cpu_wr_addr_i = a;
    #1;
    tests++;
    if (bus.cpu_wr_rdy_o !== 1'b1) begin
      fails++; $display("FAIL %s store_rdy: got %b need 1", label, bus.cpu_wr_rdy_o);
    end
    @(posedge clk); #1;
    bus.cpu_wr_vld_i = 1'b0;
    if (m_st[ix] == E && m_line[ix] == a) m_st[ix] = M;
    tests++;
    if (dut.line_state_q[ix] !== 2'(m_st[ix])) begin
      fails++; $display("FAIL %s store_state[%0d]: got %0d need %0d", label, ix, dut.line_state_q[ix], m_st[ix]);
    end
  endtask

  task automatic check_all_invalid(input string label);
    for (int i = 0; i < LINES; i++) begin
      tests++;
      if (dut.line_state_q[i] !== 2'(I)) begin
        fails++; $display("FAIL %s entry_invalid[%0d]: got %0d need 0", label, i, dut.line_state_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cbus_cmd_i    = 3'(NOP);
    bus.cbus_addr_i   = '0;
    bus.wb_ack_i      = 1'b0;
    bus.cpu_wr_vld_i  = 1'b1;
    bus.cpu_wr_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.cbus_ack_o !== 1'b0 || bus.wb_req_o !== 1'b0 || bus.wb_addr_o !== '0 || bus.cpu_wr_rdy_o !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: ack=%b wb_req=%b wb_addr=%h rdy=%b need all 0",
                        bus.cbus_ack_o, bus.wb_req_o, bus.wb_addr_o, bus.cpu_wr_rdy_o);
    end
    check_all_invalid("reset");
    bus.cpu_wr_vld_i = 1'b0;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_cmd("en_wr_25", ENW, 32'h25, 0, 0);
    run_cmd("rd_snoop_25", RDS, 32'h25, 3, 0);
    tests++;
    if (dut.line_state_q[5] !== 2'(S)) begin
      fails++; $display("FAIL basic_entry5: got %0d need %0d", dut.line_state_q[5], S);
    end
  endtask

  task automatic test_store_upgrade();
    run_cmd("en_rd_13", ENR, 32'h13, 0, 0);
    cpu_store("store_13", 32'h13);
    run_cmd("wr_snoop_13", WRS, 32'h13, 0, 0);
  endtask

  task automatic test_victim();
    run_cmd("en_wr_07", ENW, 32'h07, 0, 0);
    run_cmd("en_rd_17", ENR, 32'h17, 1, 0);
    run_cmd("en_wr_17_same", ENW, 32'h17, 0, 0);
  endtask

  task automatic test_conflict();
    run_cmd("en_rd_2a", ENR, 32'h2A, 0, 0);
    bus.cpu_wr_vld_i  = 1'b1;
    bus.cpu_wr_addr_i = 32'h2A;
    run_cmd("snoop_vs_store", WRS, 32'h44, 0, 2);
    tests++;
    if (dut.line_state_q[10] !== 2'(E)) begin
      fails++; $display("FAIL conflict_stalled: got %0d need %0d", dut.line_state_q[10], E);
    end
    cpu_store("store_after_drain", 32'h2A);
  endtask

  task automatic test_undef_codes();
    for (int c = 5; c < 8; c++) run_cmd("undef_code", c, 32'h25, 0, 0);
  endtask

  task automatic test_reset_mid_wb();
    run_cmd("en_wr_31", ENW, 32'h31, 0, 0);
    bus.cbus_cmd_i  = 3'(RDS);
    bus.cbus_addr_i = 32'h31;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.wb_req_o !== 1'b1) begin
      fails++; $display("FAIL mid_wb_req: got %b need 1", bus.wb_req_o);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.wb_req_o !== 1'b0 || bus.cbus_ack_o !== 1'b0) begin
      fails++; $display("FAIL mid_wb_reset: wb_req=%b ack=%b need 0/0", bus.wb_req_o, bus.cbus_ack_o);
    end
    check_all_invalid("mid_wb");
    bus.cbus_cmd_i = 3'(NOP);
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    run_cmd("rd_after_reset", RDS, 32'h31, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 2) cpu_store("rand_store", a);
      else run_cmd("rand_cmd", int'($urandom_range(1, 7)), a,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
  endtask

`ifdef MESI_SNOOP_STATS_EN
  task automatic test_stats();
    tests++;
    if (snoop_hit_cnt !== 16'(m_hits) || wb_cnt !== 16'(m_wbs)) begin
      fails++; $display("FAIL stats: hits=%0d wbs=%0d need %0d/%0d", snoop_hit_cnt, wb_cnt, m_hits, m_wbs);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_store_upgrade();
    test_victim();
    test_conflict();
    test_undef_codes();
    test_reset_mid_wb();
    test_random();
`ifdef MESI_SNOOP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
